// File: rtl/note_scorer.sv
`timescale 1ns/1ps
// note_scorer: three-lane rhythm game scorer.
// Synchronizes and edge-detects the lane buttons, classifies each lane's
// press / note-exit as hit, miss or ignored, and keeps score, combo and
// miss totals while a game is in PLAY. The game ends as WIN when the score
// reaches TARGET_SCORE or as LOSE when misses reach MAX_MISS.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   start       level, IDLE -> PLAY (clears counters and consumed flags)
//   abort       level, PLAY/WIN/LOSE -> IDLE (counters hold)
//   btn[2:0]    raw asynchronous lane buttons ([2]=red, [1]=green, [0]=blue)
//   note_near   per lane, a note is inside the hit window
//   note_exit   per lane, one-cycle pulse when a note leaves the screen
//   score       accumulated points, saturating at 255
//   combo       consecutive hits since the last miss, saturating at 63
//   miss_count  total misses, saturating at 15
//   hit_pulse   per lane, one-cycle hit indication
//   miss_pulse  per lane, one-cycle miss indication
//   state       IDLE=00, PLAY=01, WIN=10, LOSE=11
module note_scorer #(
    parameter logic [7:0] TARGET_SCORE = 8'd100,
    parameter logic [3:0] MAX_MISS     = 4'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] btn,
    input  logic [2:0] note_near,
    input  logic [2:0] note_exit,
    output logic [7:0] score,
    output logic [5:0] combo,
    output logic [3:0] miss_count,
    output logic [2:0] hit_pulse,
    output logic [2:0] miss_pulse,
    output logic [1:0] state
);

    localparam int unsigned LANES   = 3;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned COMBO_W = 6;
    localparam int unsigned MISS_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LANES-1:0] sync1_q;
    logic [LANES-1:0] sync2_q;
    logic [LANES-1:0] prev_q;
    logic [LANES-1:0] armed_q;
    logic [1:0]       settle_q;
    logic [LANES-1:0] consumed_q;
    logic [LANES-1:0] consumed_d;

    logic [LANES-1:0] press_c;
    logic [LANES-1:0] hit_c;
    logic [LANES-1:0] miss_c;
    logic [1:0]       nhit_c;
    logic [1:0]       nmiss_c;
    logic [2:0]       points_c;

    logic [SCORE_W:0] score_sum_c;
    logic [COMBO_W:0] combo_sum_c;
    logic [MISS_W:0]  miss_sum_c;
    logic [SCORE_W-1:0] score_upd_c;
    logic [COMBO_W-1:0] combo_upd_c;
    logic [MISS_W-1:0]  miss_upd_c;

    logic [SCORE_W-1:0] score_d;
    logic [COMBO_W-1:0] combo_d;
    logic [MISS_W-1:0]  miss_d;
    logic [LANES-1:0]   hit_d;
    logic [LANES-1:0]   missp_d;

    // Button synchronizer and rising-edge detector.
    // settle_q marks when sync2_q carries real button samples after reset;
    // a lane is only armed once it has been seen low, so a button held
    // through reset produces no strobe until it is released and pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            armed_q  <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_q | ({LANES{settle_q[1]}} & ~sync2_q);
        end
    end

    // Per-lane event classification; a miss suppresses a same-lane hit.
    always_comb begin
        press_c = sync2_q & ~prev_q & armed_q;
        miss_c  = (press_c & ~note_near) | (note_exit & ~consumed_q);
        hit_c   = press_c & note_near & ~consumed_q & ~miss_c;
    end

    // Event counts and saturating counter updates.
    always_comb begin
        nhit_c  = '0;
        nmiss_c = '0;
        for (int i = 0; i < LANES; i++) begin
            nhit_c  = nhit_c + 2'(hit_c[i]);
            nmiss_c = nmiss_c + 2'(miss_c[i]);
        end

        // Points per hit depend on the combo held before this cycle.
        points_c = (combo >= 6'd8) ? {nhit_c, 1'b0} : {1'b0, nhit_c};

        score_sum_c = 9'(score) + 9'(points_c);
        combo_sum_c = 7'(combo) + 7'(nhit_c);
        miss_sum_c  = 5'(miss_count) + 5'(nmiss_c);

        score_upd_c = score_sum_c[SCORE_W] ? 8'hFF : score_sum_c[SCORE_W-1:0];
        if (nmiss_c != 2'd0) begin
            combo_upd_c = '0;
        end else if (combo_sum_c > 7'd63) begin
            combo_upd_c = 6'd63;
        end else begin
            combo_upd_c = combo_sum_c[COMBO_W-1:0];
        end
        miss_upd_c = miss_sum_c[MISS_W] ? 4'hF : miss_sum_c[MISS_W-1:0];
    end

    // Game state machine: next state and next register values.
    always_comb begin
        state_d    = state_q;
        score_d    = score;
        combo_d    = combo;
        miss_d     = miss_count;
        hit_d      = '0;
        missp_d    = '0;
        consumed_d = consumed_q & note_near;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    combo_d    = '0;
                    miss_d     = '0;
                    consumed_d = '0;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    score_d    = score_upd_c;
                    combo_d    = combo_upd_c;
                    miss_d     = miss_upd_c;
                    hit_d      = hit_c;
                    missp_d    = miss_c;
                    consumed_d = (consumed_q | hit_c) & note_near;
                    // Loss is checked first so it wins a simultaneous win.
                    if (miss_upd_c >= MAX_MISS) begin
                        state_d = ST_LOSE;
                    end else if (score_upd_c >= TARGET_SCORE) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            score      <= '0;
            combo      <= '0;
            miss_count <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            consumed_q <= '0;
        end else begin
            state_q    <= state_d;
            score      <= score_d;
            combo      <= combo_d;
            miss_count <= miss_d;
            hit_pulse  <= hit_d;
            miss_pulse <= missp_d;
            consumed_q <= consumed_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_note_scorer.sv
`timescale 1ns/1ps
// Testbench for note_scorer: planned stimulus (directed + random) is fed to
// two instances (TARGET_SCORE 255 and 5); a rule-level game model predicts
// each cycle's outputs into queues that monitors pop and compare.
module tb_note_scorer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] btn;
    logic [2:0] note_near;
    logic [2:0] note_exit;

    logic [7:0] score,      score_w;
    logic [5:0] combo,      combo_w;
    logic [3:0] miss_count, miss_count_w;
    logic [2:0] hit_pulse,  hit_pulse_w;
    logic [2:0] miss_pulse, miss_pulse_w;
    logic [1:0] state,      state_w;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic [2:0] press;
        logic [2:0] near;
        logic [2:0] ex;
        logic       start;
        logic       abort;
    } step_t;

    typedef struct {
        int         st;
        int         score;
        int         combo;
        int         misses;
        logic [2:0] used;
        logic [2:0] hit;
        logic [2:0] miss;
    } mdl_t;

    typedef struct {
        int         cycle;
        int         st;
        int         score;
        int         combo;
        int         misses;
        logic [2:0] hit;
        logic [2:0] miss;
    } exp_t;

    step_t      plan[$];
    exp_t       exp_q[$];
    exp_t       expw_q[$];
    mdl_t       mdl;
    mdl_t       mdl_w;
    logic [2:0] last_press;

    note_scorer #(.TARGET_SCORE(8'd255), .MAX_MISS(4'd10)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .btn(btn),
        .note_near(note_near), .note_exit(note_exit), .score(score),
        .combo(combo), .miss_count(miss_count), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .state(state)
    );

    note_scorer #(.TARGET_SCORE(8'd5), .MAX_MISS(4'd10)) dut_w (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .btn(btn),
        .note_near(note_near), .note_exit(note_exit), .score(score_w),
        .combo(combo_w), .miss_count(miss_count_w), .hit_pulse(hit_pulse_w),
        .miss_pulse(miss_pulse_w), .state(state_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic mdl_t model_zero();
        mdl_t r;
        r.st = 0; r.score = 0; r.combo = 0; r.misses = 0;
        r.used = '0; r.hit = '0; r.miss = '0;
        return r;
    endfunction

    // Game rules applied to one evaluated cycle (press = debounced strobe).
    function automatic mdl_t model_step(input mdl_t m, input step_t s, input int target);
        mdl_t r;
        int pts, nh, nm;
        bit h, ms;
        r = m; r.hit = '0; r.miss = '0;
        pts = 0; nh = 0; nm = 0;
        if (m.st == 0) begin
            if (s.start) begin
                r.st = 1; r.score = 0; r.combo = 0; r.misses = 0; r.used = '0;
            end
        end else if (s.abort) begin
            r.st = 0;
        end else if (m.st == 1) begin
            for (int l = 0; l < 3; l++) begin
                h  = s.press[l] && s.near[l] && !m.used[l];
                ms = (s.press[l] && !s.near[l]) || (s.ex[l] && !m.used[l]);
                if (ms) begin
                    r.miss[l] = 1'b1; nm++;
                end else if (h) begin
                    r.hit[l] = 1'b1; nh++; r.used[l] = 1'b1;
                    pts += (m.combo >= 8) ? 2 : 1;
                end
            end
            r.score  = (m.score + pts > 255) ? 255 : m.score + pts;
            r.combo  = (nm > 0) ? 0 : ((m.combo + nh > 63) ? 63 : m.combo + nh);
            r.misses = (m.misses + nm > 15) ? 15 : m.misses + nm;
            if (r.misses >= 10)        r.st = 3;
            else if (r.score >= target) r.st = 2;
        end
        for (int l = 0; l < 3; l++) if (!s.near[l]) r.used[l] = 1'b0;
        return r;
    endfunction

    function automatic exp_t mk_exp(input mdl_t m, input int c);
        exp_t e;
        e.cycle = c; e.st = m.st; e.score = m.score; e.combo = m.combo;
        e.misses = m.misses; e.hit = m.hit; e.miss = m.miss;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    // A lane cannot press on consecutive steps: the button must fall between.
    task automatic add(input logic [2:0] pr, input logic [2:0] nr, input logic [2:0] ex,
                       input logic st, input logic ab);
        step_t s;
        s.press = pr & ~last_press; s.near = nr; s.ex = ex; s.start = st; s.abort = ab;
        plan.push_back(s);
        last_press = s.press;
    endtask

    task automatic begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic end_plan();
        for (int i = 0; i < 3; i++) add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    // Button for a step is raised three edges before that step is evaluated.
    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            @(posedge clk); #1;
            s = plan.pop_front();
            start     = s.start;
            abort     = s.abort;
            note_near = s.near;
            note_exit = s.ex;
            btn       = (plan.size() > 1) ? plan[1].press : 3'b000;
            mdl   = model_step(mdl, s, 255);
            mdl_w = model_step(mdl_w, s, 5);
            exp_q.push_back(mk_exp(mdl, cyc + 1));
            expw_q.push_back(mk_exp(mdl_w, cyc + 1));
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; note_near = '0; note_exit = '0; btn = '0;
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (state !== 2'(e.st) || score !== 8'(e.score) || combo !== 6'(e.combo) ||
                miss_count !== 4'(e.misses) || hit_pulse !== e.hit || miss_pulse !== e.miss) begin
                errors++;
                $display("FAIL main cyc=%0d got st=%0d sc=%0d co=%0d mi=%0d hp=%b mp=%b exp st=%0d sc=%0d co=%0d mi=%0d hp=%b mp=%b",
                         cyc, state, score, combo, miss_count, hit_pulse, miss_pulse,
                         e.st, e.score, e.combo, e.misses, e.hit, e.miss);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (expw_q.size() > 0 && expw_q[0].cycle == cyc) begin
            e = expw_q.pop_front();
            checks++;
            if (state_w !== 2'(e.st) || score_w !== 8'(e.score) || combo_w !== 6'(e.combo) ||
                miss_count_w !== 4'(e.misses) || hit_pulse_w !== e.hit || miss_pulse_w !== e.miss) begin
                errors++;
                $display("FAIL win5 cyc=%0d got st=%0d sc=%0d co=%0d mi=%0d hp=%b mp=%b exp st=%0d sc=%0d co=%0d mi=%0d hp=%b mp=%b",
                         cyc, state_w, score_w, combo_w, miss_count_w, hit_pulse_w, miss_pulse_w,
                         e.st, e.score, e.combo, e.misses, e.hit, e.miss);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pr, nr, ex;
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        btn = '0; note_near = '0; note_exit = '0;
        mdl = model_zero(); mdl_w = model_zero(); last_press = '0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        check("rst_combo", int'(combo), 0);
        check("rst_miss", int'(miss_count), 0);
        check("rst_hit_pulse", int'(hit_pulse), 0);
        check("rst_miss_pulse", int'(miss_pulse), 0);
        check("rst_state_w", int'(state_w), 0);
        repeat (3) @(posedge clk);

        // Single hit, ignored repeat press, combo build-up, mixed events.
        begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        add(3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b100, 3'b000, 1'b0, 1'b0);
        add(3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            add(3'b001, 3'b001, 3'b000, 1'b0, 1'b0);
            add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        add(3'b110, 3'b110, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        add(3'b110, 3'b111, 3'b001, 1'b0, 1'b0);
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end_plan();
        run_plan();

        // Loss by wrong presses, then presses after LOSE.
        begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        add(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            add(3'b100, 3'b000, 3'b000, 1'b0, 1'b0);
            add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        end_plan();
        run_plan();

        // Saturation: combo reaches 63, score clamps at 255; TARGET 5 wins early.
        begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        add(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        add(3'b001, 3'b001, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            add(3'b111, 3'b111, 3'b000, 1'b0, 1'b0);
            add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        end_plan();
        run_plan();

        // Randomized play with occasional starts and aborts.
        begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 700; k++) begin
            nr = 3'($urandom);
            pr = 3'($urandom) & 3'($urandom);
            ex = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            add(pr, nr, ex, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 24) == 0));
        end
        end_plan();
        run_plan();

        // Mid-game reset between edges with buttons held high.
        begin_plan();
        add(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        add(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            add(3'b011, 3'b011, 3'b000, 1'b0, 1'b0);
            add(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        end_plan();
        run_plan();
        check("pre_reset_score", int'(score), mdl.score);
        check("pre_reset_combo", int'(combo), mdl.combo);

        btn = 3'b111; note_near = 3'b111;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_score", int'(score), 0);
        check("async_rst_combo", int'(combo), 0);
        check("async_rst_miss", int'(miss_count), 0);
        check("async_rst_pulses", int'({hit_pulse, miss_pulse}), 0);
        check("async_rst_state_w", int'(state_w), 0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_score", int'(score), 0);
        check("restart_combo", int'(combo), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("held_btn_no_pulse", int'({hit_pulse, miss_pulse}), 0);
        end
        btn = '0; note_near = '0;
        repeat (4) @(posedge clk);
        mdl = model_zero(); mdl.st = 1;
        mdl_w = model_zero(); mdl_w.st = 1;
        begin_plan();
        add(3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
        add(3'b000, 3'b100, 3'b000, 1'b0, 1'b0);
        add(3'b010, 3'b000, 3'b000, 1'b0, 1'b0);
        end_plan();
        run_plan();

        check("sb_drain", exp_q.size() + expw_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_scorer.md
NOTE_SCORER -- requirements
Module: note_scorer

Interface
REQ-001 SHALL provide parameter TARGET_SCORE, default 8'd100, meaning the score at or above which the game ends as a win.
REQ-002 SHALL provide parameter MAX_MISS, default 4'd10, meaning the miss count at which the game ends as a loss.
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  level; starts a game from IDLE.
REQ-006 SHALL provide port abort  input  1  level; returns to IDLE from PLAY or DONE.
REQ-007 SHALL provide port btn  input  3  raw, asynchronous lane buttons: [2]=red, [1]=green, [0]=blue.
REQ-008 SHALL provide port note_near  input  3  per lane, level; a falling note is inside the hit window.
REQ-009 SHALL provide port note_exit  input  3  per lane, one-cycle pulse; a note left the bottom of the screen.
REQ-010 SHALL provide port score  output  8  accumulated points.
REQ-011 SHALL provide port combo  output  6  consecutive hits since the last miss.
REQ-012 SHALL provide port miss_count  output  4  total misses.
REQ-013 SHALL provide port hit_pulse  output  3  per lane, one-cycle hit indication.
REQ-014 SHALL provide port miss_pulse  output  3  per lane, one-cycle miss indication.
REQ-015 SHALL provide port state  output  2  current state: IDLE=2'b00, PLAY=2'b01, WIN=2'b10, LOSE=2'b11.

Function
REQ-016 SHALL pass each btn bit through a 2-flop synchronizer followed by a rising-edge detector, giving a one-cycle press strobe.
- The strobe, and any hit_pulse or miss_pulse it causes, appear on the 3rd rising clk edge after btn rises.
REQ-017 SHALL move IDLE->PLAY when start=1.
- On that edge, clear score, combo, miss_count and all consumed flags.
REQ-018 SHALL move PLAY->WIN when the updated score is >= TARGET_SCORE.
REQ-019 SHALL move PLAY->LOSE when the updated miss_count is >= MAX_MISS.
- If both conditions become true in the same cycle, LOSE wins.
REQ-020 SHALL move PLAY, WIN or LOSE to IDLE when abort=1.
- score, combo and miss_count hold their values on this transition.
- abort takes priority over every other transition.
REQ-021 SHALL evaluate presses and exits only in PLAY; in IDLE, WIN and LOSE no pulses are produced and counters hold.
REQ-022 SHALL keep one consumed flag per lane.
- Set on a hit in that lane.
- Cleared on any cycle where note_near for that lane is 0.
REQ-023 SHALL classify each lane event per cycle as follows:
- Hit: press strobe with note_near=1 and consumed=0.
- Miss (wrong press): press strobe with note_near=0.
- Ignored: press strobe with note_near=1 and consumed=1.
- Miss (unhit note): note_exit=1 with consumed=0.
REQ-024 SHALL produce at most one pulse per lane per cycle; if a lane has both a hit and a miss in the same cycle, report the miss only.
REQ-025 SHALL award points per hit based on the combo value registered before the cycle:
- 1 point when combo < 8.
- 2 points when combo >= 8.
REQ-026 SHALL, per cycle, add the sum over all hit lanes to score, saturating at 255.
REQ-027 SHALL update combo per cycle as follows:
- Set to 0 if any lane misses in that cycle (a miss outweighs simultaneous hits).
- Otherwise add the number of hits, saturating at 63.
REQ-028 SHALL add the number of missed lanes to miss_count each cycle, saturating at 15.
REQ-029 SHALL register all outputs; hit_pulse and miss_pulse are high for exactly one cycle per event.

Reset
REQ-030 SHALL, while reset=1, asynchronously force the following, regardless of clk:
- state=IDLE.
- score=0, combo=0, miss_count=0, hit_pulse=0, miss_pulse=0.
- All consumed flags and synchronizer/edge flops to 0.
REQ-031 SHALL, on reset deassertion with btn held high, produce no press strobe until btn falls and rises again.

Verification
REQ-032 Single hit: PLAY, note_near=3'b100, btn[2] rises -> hit_pulse=3'b100 on the 3rd edge; score=1, combo=1; a second press in the same window -> no pulse.
REQ-033 Simultaneous mixed events: combo=8, btn[2] and btn[1] pressed with note_near=3'b110 -> score +4, combo=10; repeat with note_exit[0]=1 and lane 0 unconsumed -> score +4, combo=0, miss_count +1, miss_pulse=3'b001.
REQ-034 Loss: 10 wrong presses with note_near=0 -> miss_count=10, state=LOSE; further presses produce no pulses.
REQ-035 Win and saturation: TARGET_SCORE=5, hits until score>=5 -> state=WIN; with TARGET_SCORE=255, score stops at 255 and combo stops at 63.
REQ-036 Reset mid-game: score=37, combo=12, reset pulse between clk edges -> all outputs 0 immediately and state=IDLE; start -> PLAY with counters 0.
